// File: rtl/pll_ctrl_pkg.sv
// Purpose: shared state encoding, default timing constants and output decode for the PLL lock supervisor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: pll_state_t (FSM states), DEF_* cycle constants, pll_outs_t and decode_outs().
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } pll_state_t;

  // Defaults sized for a 50 MHz refclk.
  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_RELEASE_DLY_CYC  = 64;
  localparam int DEF_MAX_RETRIES      = 3;
  localparam int DEF_CNT_W            = 16;

  typedef struct packed {
    logic pll_rst;
    logic rst_out;
    logic ready;
    logic fault;
  } pll_outs_t;

  // Moore output decode; the top registers this against the next state so
  // every output changes on the edge that enters the new state.
  function automatic pll_outs_t decode_outs(input pll_state_t s);
    pll_outs_t o;
    o.pll_rst = (s == S_PLL_RST) || (s == S_FAULT);
    o.rst_out = (s != S_RUN);
    o.ready   = (s == S_RUN);
    o.fault   = (s == S_FAULT);
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchroniser for a single asynchronous level input.
// Latency: 2 clk edges from d to q.
// Backpressure: none; free-running level path.
// Ports: clk, rst (sync, active-high, clears both flops), d (async in), q (synchronised out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Purpose: sequences PLL reset, waits for lock with timeout and bounded retries, qualifies lock, gates datapath reset.
// Latency: locked_s first seen in WAIT_LOCK -> ready after 1+LOCK_STABLE_CYC+RELEASE_DLY_CYC edges (+2 from pll_locked pin).
// Backpressure: none; sw_restart is a single-cycle pulse and always accepted.
// Ports: refclk, rst (sync, active-high), pll_locked (async), sw_restart -> pll_rst, rst_out, ready, fault,
//        retry_cnt (failed attempts this sequence), loss_cnt (RUN lock losses, saturating).
module pll_lock_supervisor
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int RELEASE_DLY_CYC  = DEF_RELEASE_DLY_CYC,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sw_restart,
  output logic       pll_rst,
  output logic       rst_out,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  // Terminal timer values: each timed state exits when the timer holds N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DLY_CYC - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  logic             locked_s;
  pll_state_t       state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [1:0]       retry_nxt;
  logic [7:0]       loss_nxt;
  logic             attempt_fail;
  pll_outs_t        outs_nxt;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer + CNT_W'(1);
    retry_nxt    = retry_cnt;
    loss_nxt     = loss_cnt;
    attempt_fail = 1'b0;

    case (state)
      S_PLL_RST: begin
        if (timer == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = S_STABLE;
          timer_nxt = '0;
        end else if (timer == TIMEOUT_LAST) begin
          attempt_fail = 1'b1;
        end
      end
      S_STABLE: begin
        // A dropout here just restarts the lock wait; the PLL did lock.
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
        end else if (timer == STABLE_LAST) begin
          state_nxt = S_RELEASE;
          timer_nxt = '0;
        end
      end
      S_RELEASE: begin
        if (!locked_s) begin
          attempt_fail = 1'b1;
        end else if (timer == RELEASE_LAST) begin
          state_nxt = S_RUN;
          timer_nxt = '0;
        end
      end
      S_RUN: begin
        // Timer parked at zero in untimed states so it can never wrap.
        timer_nxt = '0;
        if (!locked_s) begin
          state_nxt = S_PLL_RST;
          retry_nxt = '0;
          if (loss_cnt != 8'hFF) begin
            loss_nxt = loss_cnt + 8'd1;
          end
        end
      end
      S_FAULT: begin
        timer_nxt = '0;
      end
      default: begin
        state_nxt = S_PLL_RST;
        timer_nxt = '0;
      end
    endcase

    // Timeout and RELEASE dropout share one retry budget.
    if (attempt_fail) begin
      timer_nxt = '0;
      if (retry_cnt == RETRY_MAX) begin
        state_nxt = S_FAULT;
      end else begin
        state_nxt = S_PLL_RST;
        retry_nxt = retry_cnt + 2'd1;
      end
    end

    // Software restart overrides everything except rst; loss history is kept.
    if (sw_restart) begin
      state_nxt = S_PLL_RST;
      timer_nxt = '0;
      retry_nxt = '0;
      loss_nxt  = loss_cnt;
    end
  end

  assign outs_nxt = decode_outs(state_nxt);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_PLL_RST;
      timer     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      rst_out   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
      pll_rst   <= outs_nxt.pll_rst;
      rst_out   <= outs_nxt.rst_out;
      ready     <= outs_nxt.ready;
      fault     <= outs_nxt.fault;
    end
  end

endmodule
